// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and its stall/flush sequencer.
// master = pipeline side (hazard inputs, reads controls); slave = sequencer side.
interface pipeline_hazard_ctrl_if #(
   parameter int PC_WIDTH = 32,
   parameter int REG_AW   = 5
);
   logic [REG_AW-1:0]   id_rs1;
   logic [REG_AW-1:0]   id_rs2;
   logic                id_rs1_used;
   logic                id_rs2_used;
   logic                ex_is_load;
   logic [REG_AW-1:0]   ex_rd;
   logic                ex_branch_taken;
   logic [PC_WIDTH-1:0] ex_branch_target;
   logic                ex_mc_req;
   logic                mc_done;
   logic                pc_stall;
   logic                pc_redirect;
   logic [PC_WIDTH-1:0] pc_target;
   logic                if_id_stall;
   logic                if_id_flush;
   logic                id_ex_stall;
   logic                id_ex_bubble;
   logic                mc_start;
   logic                mc_err;

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      output ex_is_load, ex_rd, ex_branch_taken,
      output ex_branch_target, ex_mc_req, mc_done,
      input  pc_stall, pc_redirect, pc_target,
      input  if_id_stall, if_id_flush,
      input  id_ex_stall, id_ex_bubble,
      input  mc_start, mc_err
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
      input  ex_is_load, ex_rd, ex_branch_taken,
      input  ex_branch_target, ex_mc_req, mc_done,
      output pc_stall, pc_redirect, pc_target,
      output if_id_stall, if_id_flush,
      output id_ex_stall, id_ex_bubble,
      output mc_start, mc_err
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: branch redirect, load-use bubble, mul/div wait, imem flush.
// Ports: clk, rst (async, active-low), hz (slave: hazard inputs in, PC/IF-ID/ID-EX controls out).
module pipeline_hazard_ctrl #(
   parameter int PC_WIDTH   = 32,
   parameter int REG_AW     = 5,
   parameter int IMEM_LAT   = 1,
   parameter int MC_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int WW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   // Last wait count before giving up; start cycle plus waits equals MC_TIMEOUT.
   localparam logic [WW-1:0] W_LAST = WW'(MC_TIMEOUT - 2);
   localparam logic [1:0]    F_LOAD = 2'(IMEM_LAT);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [1:0]        fcnt, fcnt_n;
   logic [WW-1:0]     wcnt, wcnt_n;
   logic              err, err_n;

   logic [REG_AW-1:0] rd;
   logic              br;
   logic              load_use;

   logic              pc_stall_c, pc_redirect_c, if_id_stall_c;
   logic              if_id_flush_c, id_ex_stall_c, id_ex_bubble_c;
   logic              mc_start_c;
   logic [PC_WIDTH-1:0] target_c;

   assign rd = hz.ex_rd;
   assign br = hz.ex_branch_taken;
   assign load_use = hz.ex_is_load && (rd != '0) &&
                     ((hz.id_rs1_used && (hz.id_rs1 == rd)) ||
                      (hz.id_rs2_used && (hz.id_rs2 == rd)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         fcnt  <= '0;
         wcnt  <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         fcnt  <= fcnt_n;
         wcnt  <= wcnt_n;
         err   <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      fcnt_n  = fcnt;
      wcnt_n  = wcnt;
      err_n   = err;
      unique case (state)
         RUN: begin
            if (br) begin
               if (IMEM_LAT > 0) begin
                  state_n = FLUSH;
                  fcnt_n  = F_LOAD;
               end
            end else if (hz.ex_mc_req) begin
               state_n = MC_WAIT;
               wcnt_n  = '0;
            end
         end
         MC_WAIT: begin
            if (hz.mc_done) begin
               state_n = RUN;
            end else begin
               wcnt_n = wcnt + 1'b1;
               if (wcnt == W_LAST) begin
                  err_n   = 1'b1;
                  state_n = RUN;
               end
            end
         end
         FLUSH: begin
            if (br) begin
               fcnt_n = F_LOAD;
            end else begin
               fcnt_n = fcnt - 2'd1;
               if (fcnt == 2'd1) state_n = RUN;
            end
         end
         default: state_n = RUN;
      endcase
   end

   always_comb begin
      pc_stall_c     = 1'b0;
      pc_redirect_c  = 1'b0;
      if_id_stall_c  = 1'b0;
      if_id_flush_c  = 1'b0;
      id_ex_stall_c  = 1'b0;
      id_ex_bubble_c = 1'b0;
      mc_start_c     = 1'b0;
      // Reset blanks every control, even mid-sequence.
      if (rst) begin
         unique case (state)
            RUN: begin
               if (br) begin
                  pc_redirect_c  = 1'b1;
                  if_id_flush_c  = 1'b1;
                  id_ex_bubble_c = 1'b1;
               end else if (hz.ex_mc_req) begin
                  mc_start_c    = 1'b1;
                  pc_stall_c    = 1'b1;
                  if_id_stall_c = 1'b1;
                  id_ex_stall_c = 1'b1;
               end else if (load_use) begin
                  pc_stall_c     = 1'b1;
                  if_id_stall_c  = 1'b1;
                  id_ex_bubble_c = 1'b1;
               end
            end
            MC_WAIT: begin
               if (!hz.mc_done) begin
                  pc_stall_c    = 1'b1;
                  if_id_stall_c = 1'b1;
                  id_ex_stall_c = 1'b1;
               end
            end
            FLUSH: begin
               if_id_flush_c = 1'b1;
               if (br) begin
                  pc_redirect_c  = 1'b1;
                  id_ex_bubble_c = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      target_c = '0;
      if (pc_redirect_c) target_c = hz.ex_branch_target;
   end

   assign hz.pc_stall     = pc_stall_c;
   assign hz.pc_redirect  = pc_redirect_c;
   assign hz.pc_target    = target_c;
   assign hz.if_id_stall  = if_id_stall_c;
   assign hz.if_id_flush  = if_id_flush_c;
   assign hz.id_ex_stall  = id_ex_stall_c;
   assign hz.id_ex_bubble = id_ex_bubble_c;
   assign hz.mc_start     = mc_start_c;
   assign hz.mc_err       = err & rst;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run
// against a behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;
   localparam int PW  = 32;
   localparam int AW  = 5;
   localparam int LAT = 1;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.PC_WIDTH(PW), .REG_AW(AW)) hz ();

   pipeline_hazard_ctrl #(
      .PC_WIDTH(PW), .REG_AW(AW),
      .IMEM_LAT(LAT), .MC_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz(hz)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: remaining extra flush cycles, multi-cycle op in progress,
   // number of cycles stalled so far by that op, sticky error.
   int m_flush_left = 0;
   bit m_busy       = 1'b0;
   int m_stalled    = 0;
   bit m_err        = 1'b0;

   logic [39:0] act_v, exp_v, want;

   function automatic logic [39:0] vec(bit ps, bit pr, logic [31:0] tg,
                                       bit fs, bit ff, bit es, bit eb,
                                       bit st, bit er);
      return {ps, pr, tg, fs, ff, es, eb, st, er};
   endfunction

   function automatic logic [39:0] dut_vec();
      return {hz.pc_stall, hz.pc_redirect, hz.pc_target,
              hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall,
              hz.id_ex_bubble, hz.mc_start, hz.mc_err};
   endfunction

   function automatic bit lu_hit();
      return hz.ex_is_load && (hz.ex_rd != 0) &&
             ((hz.id_rs1_used && hz.id_rs1 == hz.ex_rd) ||
              (hz.id_rs2_used && hz.id_rs2 == hz.ex_rd));
   endfunction

   function automatic logic [39:0] model_out();
      if (!rst) return '0;
      if (m_busy) begin
         if (!hz.mc_done)
            return vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_err);
         return vec(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_err);
      end
      if (hz.ex_branch_taken)
         return vec(1'b0, 1'b1, hz.ex_branch_target, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_err);
      if (m_flush_left > 0)
         return vec(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_err);
      if (hz.ex_mc_req)
         return vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, m_err);
      if (lu_hit())
         return vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, m_err);
      return vec(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_err);
   endfunction

   task automatic model_reset();
      m_flush_left = 0;
      m_busy       = 1'b0;
      m_stalled    = 0;
      m_err        = 1'b0;
   endtask

   task automatic model_advance();
      if (!rst) begin
         model_reset();
      end else if (m_busy) begin
         if (hz.mc_done) begin
            m_busy = 1'b0;
         end else begin
            m_stalled++;
            if (m_stalled == TMO) begin
               m_err  = 1'b1;
               m_busy = 1'b0;
            end
         end
      end else if (hz.ex_branch_taken) begin
         m_flush_left = LAT;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
      end else if (hz.ex_mc_req) begin
         m_busy    = 1'b1;
         m_stalled = 1;
      end
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      #1;
      exp_v = model_out();
      act_v = dut_vec();
      @(posedge clk);
      model_advance();
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle();
      hz.id_rs1           = '0;
      hz.id_rs2           = '0;
      hz.id_rs1_used      = 1'b0;
      hz.id_rs2_used      = 1'b0;
      hz.ex_is_load       = 1'b0;
      hz.ex_rd            = '0;
      hz.ex_branch_taken  = 1'b0;
      hz.ex_branch_target = '0;
      hz.ex_mc_req        = 1'b0;
      hz.mc_done          = 1'b0;
   endtask

   task automatic rand_inputs();
      hz.id_rs1           = 5'($urandom_range(0, 7));
      hz.id_rs2           = 5'($urandom_range(0, 7));
      hz.id_rs1_used      = 1'($urandom_range(0, 1));
      hz.id_rs2_used      = 1'($urandom_range(0, 1));
      hz.ex_is_load       = 1'($urandom_range(0, 1));
      hz.ex_rd            = 5'($urandom_range(0, 7));
      hz.ex_branch_taken  = ($urandom_range(0, 7) == 0);
      hz.ex_branch_target = $urandom;
      hz.ex_mc_req        = ($urandom_range(0, 5) == 0);
      hz.mc_done          = ($urandom_range(0, 4) == 0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         hz.ex_branch_taken = 1'b1;
         want = '0;
         step();
         if (act_v !== want) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, act_v, want);
         end
         total++;
      end
      idle();
      rst = 1'b1;
      want = '0;
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
   endtask

   task automatic test_load_use();
      hz.ex_is_load  = 1'b1;
      hz.ex_rd       = 5'd5;
      hz.id_rs2      = 5'd5;
      hz.id_rs2_used = 1'b1;
      hz.id_rs1      = 5'd3;
      hz.id_rs1_used = 1'b1;
      want = vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL lu_rs2 cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      hz.ex_is_load = 1'b0;
      want = '0;
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL lu_after cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      hz.ex_is_load = 1'b1;
      hz.ex_rd      = 5'd0;
      hz.id_rs2     = 5'd0;
      hz.id_rs1     = 5'd0;
      want = '0;
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL lu_x0 cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      hz.ex_rd       = 5'd9;
      hz.id_rs1      = 5'd9;
      hz.id_rs2_used = 1'b0;
      hz.id_rs1_used = 1'b0;
      want = '0;
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL lu_unused cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      hz.id_rs1_used = 1'b1;
      want = vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL lu_rs1 cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
   endtask

   task automatic test_branch();
      hz.ex_branch_taken  = 1'b1;
      hz.ex_branch_target = 32'h0000_0040;
      want = vec(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL br_c0 cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
      hz.ex_mc_req   = 1'b1;
      hz.ex_is_load  = 1'b1;
      hz.ex_rd       = 5'd4;
      hz.id_rs1      = 5'd4;
      hz.id_rs1_used = 1'b1;
      want = vec(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL br_c1 cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
      want = '0;
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL br_c2 cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
   endtask

   task automatic test_multicycle();
      logic [39:0] stl;
      stl = vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      hz.ex_mc_req = 1'b1;
      want = vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL mc_start cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      for (int i = 1; i < 6; i++) begin
         idle();
         hz.ex_mc_req       = 1'b1;
         hz.ex_branch_taken = (i == 3);
         step();
         if (act_v !== stl) begin
            bad++;
            $display("FAIL mc_wait%0d cyc=%0d got=%h want=%h", i, cyc, act_v, stl);
         end
         total++;
      end
      idle();
      hz.mc_done = 1'b1;
      want = '0;
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL mc_done cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
      hz.ex_is_load  = 1'b1;
      hz.ex_rd       = 5'd7;
      hz.id_rs2      = 5'd7;
      hz.id_rs2_used = 1'b1;
      want = vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL mc_back_run cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
   endtask

   task automatic test_priority();
      hz.ex_branch_taken  = 1'b1;
      hz.ex_branch_target = 32'h0000_1234;
      hz.ex_mc_req        = 1'b1;
      hz.ex_is_load       = 1'b1;
      hz.ex_rd            = 5'd2;
      hz.id_rs1           = 5'd2;
      hz.id_rs1_used      = 1'b1;
      want = vec(1'b0, 1'b1, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL prio cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
      step();
      step();
   endtask

   task automatic test_back_to_back();
      hz.ex_branch_taken  = 1'b1;
      hz.ex_branch_target = 32'h0000_0100;
      want = vec(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL b2b_first cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      hz.ex_branch_target = 32'h0000_0200;
      want = vec(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL b2b_second cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
      want = vec(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL b2b_reload cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      want = '0;
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL b2b_end cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
   endtask

   task automatic test_timeout();
      logic [39:0] stl;
      stl = vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      hz.ex_mc_req = 1'b1;
      want = vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL tmo_start cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
      for (int i = 1; i < TMO; i++) begin
         step();
         if (act_v !== stl) begin
            bad++;
            $display("FAIL tmo_wait%0d cyc=%0d got=%h want=%h", i, cyc, act_v, stl);
         end
         total++;
      end
      want = vec(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL tmo_err cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      hz.mc_done = 1'b1;
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL tmo_sticky cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
   endtask

   task automatic test_reset_mid();
      hz.ex_mc_req = 1'b1;
      step();
      idle();
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      act_v = dut_vec();
      want  = '0;
      if (act_v !== want) begin
         bad++;
         $display("FAIL rst_async cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      model_reset();
      @(negedge clk);
      rand_inputs();
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL rst_low cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
      rst = 1'b1;
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL rst_clear cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      hz.ex_mc_req = 1'b1;
      want = vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      if (act_v !== want) begin
         bad++;
         $display("FAIL rst_run cyc=%0d got=%h want=%h", cyc, act_v, want);
      end
      total++;
      idle();
      hz.mc_done = 1'b1;
      step();
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         rand_inputs();
         rst = ($urandom_range(0, 199) != 0);
         step();
         if (act_v !== exp_v) begin
            bad++;
            $display("FAIL rand cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
         end
         total++;
      end
      idle();
      rst = 1'b1;
      step();
   endtask

   initial begin
      idle();
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_branch();
      test_multicycle();
      test_priority();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives hold/flush/bubble controls for the PC register, the IF/ID pipeline register and the ID/EX pipeline register.
- Resolves taken-branch redirects, load-use hazards and multi-cycle EX ops (mul/div) with a start/done handshake.
- Adds extra flush cycles to cover synchronous instruction-memory latency.

Parameters:
- PC_WIDTH, 32, width of PC and redirect target.
- REG_AW, 5, register address width.
- IMEM_LAT, 1, extra cycles if_id_flush stays high after a redirect (0..3).
- MC_TIMEOUT, 64, max MC_WAIT cycles before mc_err.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- id_rs1  in  REG_AW  ID-stage source reg 1.
- id_rs2  in  REG_AW  ID-stage source reg 2.
- id_rs1_used  in  1  rs1 is read by the ID instruction.
- id_rs2_used  in  1  rs2 is read by the ID instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  EX destination reg.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- ex_branch_target  in  PC_WIDTH  redirect address.
- ex_mc_req  in  1  EX instruction needs the multi-cycle unit.
- mc_done  in  1  multi-cycle unit result valid (1-cycle pulse).
- pc_stall  out  1  hold PC.
- pc_redirect  out  1  load PC from pc_target.
- pc_target  out  PC_WIDTH  redirect address.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  zero IF/ID (inst=0, pc=0).
- id_ex_stall  out  1  hold ID/EX.
- id_ex_bubble  out  1  load NOP into ID/EX.
- mc_start  out  1  start pulse to the multi-cycle unit.
- mc_err  out  1  sticky timeout flag.

Behaviour:
- States: RUN, MC_WAIT, FLUSH. State, flush counter (2b), wait counter and mc_err are registered. All other outputs are combinational from state and inputs (Mealy).
- rst low: state=RUN, counters=0, mc_err=0, every output forced 0 regardless of inputs. Applies immediately and mid-operation; any MC_WAIT or FLUSH is abandoned.
- pc_target = ex_branch_target whenever pc_redirect=1, else 0.
- Priority in RUN, highest first:
  1. Branch. ex_branch_taken=1: pc_redirect=1, if_id_flush=1, id_ex_bubble=1, no stalls. Next state is FLUSH with counter=IMEM_LAT if IMEM_LAT>0, else RUN.
  2. Multi-cycle op. ex_mc_req=1: mc_start=1 for this cycle only; pc_stall, if_id_stall and id_ex_stall all 1. Next state MC_WAIT, wait counter=0.
  3. Load-use. ex_is_load and ex_rd!=0 and ((id_rs1_used and id_rs1==ex_rd) or (id_rs2_used and id_rs2==ex_rd)): pc_stall=1, if_id_stall=1, id_ex_bubble=1 for exactly that cycle. Stays in RUN; the inserted bubble clears the condition on the next cycle.
  4. Otherwise all outputs 0.
- MC_WAIT:
  - mc_done=0: pc_stall, if_id_stall and id_ex_stall all 1; wait counter increments.
  - mc_done=1: all stalls 0 in that same cycle; next state RUN.
  - ex_branch_taken, ex_mc_req and load-use are ignored; mc_start stays 0.
  - Wait counter reaches MC_TIMEOUT-1 without mc_done: mc_err set (sticky until reset), stalls released, next state RUN.
- FLUSH:
  - if_id_flush=1; counter decrements; leave to RUN when the counter reaches 1.
  - A new ex_branch_taken here gets full redirect behaviour (as in RUN) and reloads the counter to IMEM_LAT.
  - ex_mc_req and load-use are ignored, since only flushed NOPs are in flight.
- ex_rd==0 never causes a load-use stall.
- mc_done arriving in RUN or FLUSH is ignored.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_rs2_used=1 → one cycle of pc_stall=if_id_stall=id_ex_bubble=1. The following cycle (ex_is_load=0) all outputs 0. Repeat with ex_rd=0 → no stall.
- Branch, IMEM_LAT=1: ex_branch_taken=1, target 0x0000_0040 → cycle 0: pc_redirect=1, pc_target=0x40, if_id_flush=1, id_ex_bubble=1. Cycle 1: if_id_flush=1 only. Cycle 2: all 0.
- Multi-cycle: ex_mc_req=1, mc_done pulses 6 cycles later → mc_start high exactly one cycle; three stalls high for 6 cycles; stalls low in the mc_done cycle; RUN afterwards.
- Timeout, MC_TIMEOUT=8: ex_mc_req=1, no mc_done → stalls high 8 cycles, then mc_err=1 and it stays 1; stalls drop.
- Priority: ex_branch_taken=1, ex_mc_req=1 and a load-use match all in the same RUN cycle → redirect/flush only, mc_start=0.
- Back-to-back branch in FLUSH reloads the flush count.
- Reset mid-MC_WAIT: drop rst to 0 asynchronously → all outputs 0 before the next edge. After release, state is RUN and mc_err=0.
